// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operation, arbiter FSM state and request types.
package alu_pkg;
    localparam int ALU_W = 8;
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_e;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;
    typedef struct packed {
        logic [2*ALU_W-1:0] a;
        logic [2*ALU_W-1:0] b;
        alu_op_e            op;
    } req_t;
endpackage

// File: rtl/alu.sv
// alu: W-bit ALU slice; ADD and SUB both add with carry-in, so SUB expects B already inverted.
module alu
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    input  alu_op_e      op_i,
    output logic [W-1:0] y_o,
    output logic         cout_o
);
    logic [W:0] sum;
    logic       arith;
    assign sum   = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
    assign arith = (op_i == OP_ADD) || (op_i == OP_SUB);
    always_comb begin
        y_o    = (op_i == OP_AND) ? (a_i & b_i) : (op_i == OP_OR) ? (a_i | b_i) : sum[W-1:0];
        cout_o = arith & sum[W];
    end
endmodule

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; last-served pointer resets to 1 so requester 0 wins the first tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);
    logic last_q, last_d;
    assign grant[0] = valid[0] & (~valid[1] | last_q);
    assign grant[1] = valid[1] & (~valid[0] | ~last_q);
    assign last_d   = advance ? grant[1] : last_q;
    always_ff @(posedge clk) begin
        last_q <= rst ? 1'b1 : last_d;
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one SLICE_W-bit ALU slice; each op runs low half then high half.
// Define ALU_ARB_FLAGS_EN to add the rsp_zero / rsp_ovf result flags.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int SLICE_W = ALU_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [2*SLICE_W-1:0] req0_a,
    input  logic [2*SLICE_W-1:0] req0_b,
    input  logic [1:0]           req0_op,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [2*SLICE_W-1:0] req1_a,
    input  logic [2*SLICE_W-1:0] req1_b,
    input  logic [1:0]           req1_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*SLICE_W-1:0] rsp_result,
    output logic                 rsp_cout,
    output logic                 busy
`ifdef ALU_ARB_FLAGS_EN
    ,
    output logic                 rsp_zero,
    output logic                 rsp_ovf
`endif
);
    localparam int DW = 2 * SLICE_W;

    state_e             state_q, state_d;
    req_t               req_q, req_d;
    logic               id_q, id_d, c_q, c_d, cout_q, cout_d;
    logic [SLICE_W-1:0] lo_q, lo_d;
    logic [DW-1:0]      res_q, res_d;
    logic [1:0]         grant;
    logic               hs, hi, sub, arith, cin, sc;
    logic [DW-1:0]      b_eff;
    logic [SLICE_W-1:0] sa, sb, sy;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  ({req1_valid, req0_valid}),
        .advance(hs),
        .grant  (grant)
    );

    assign req0_ready = (state_q == IDLE) && grant[0] && !rst;
    assign req1_ready = (state_q == IDLE) && grant[1] && !rst;
    assign hs         = req0_ready | req1_ready;

    // SUB runs as A + ~B + 1; the +1 enters as the low-pass carry-in.
    assign hi    = state_q == HI;
    assign sub   = req_q.op == OP_SUB;
    assign arith = (req_q.op == OP_ADD) || sub;
    assign b_eff = sub ? ~req_q.b : req_q.b;
    assign sa    = hi ? req_q.a[DW-1:SLICE_W] : req_q.a[SLICE_W-1:0];
    assign sb    = hi ? b_eff[DW-1:SLICE_W] : b_eff[SLICE_W-1:0];
    assign cin   = hi ? c_q : sub;

    alu #(.W(SLICE_W)) u_alu (
        .a_i   (sa),
        .b_i   (sb),
        .cin_i (cin),
        .op_i  (req_q.op),
        .y_o   (sy),
        .cout_o(sc)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        id_d    = id_q;
        lo_d    = lo_q;
        c_d     = c_q;
        res_d   = res_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: if (hs) begin
                state_d  = LO;
                id_d     = grant[1];
                req_d.a  = grant[1] ? req1_a : req0_a;
                req_d.b  = grant[1] ? req1_b : req0_b;
                req_d.op = alu_op_e'(grant[1] ? req1_op : req0_op);
            end
            LO: begin
                state_d = HI;
                lo_d    = sy;
                c_d     = sc;
            end
            HI: begin
                state_d = DONE;
                res_d   = {sy, lo_q};
                cout_d  = sc;
            end
            DONE: state_d = rsp_ready ? IDLE : DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            id_q    <= 1'b0;
            lo_q    <= '0;
            c_q     <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            id_q    <= id_d;
            lo_q    <= lo_d;
            c_q     <= c_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
        end
    end

    assign rsp_valid  = state_q == DONE;
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_cout   = cout_q;
    assign busy       = state_q != IDLE;

`ifdef ALU_ARB_FLAGS_EN
    logic zero_q, zero_d, ovf_q, ovf_d;
    // Signed overflow: operands (with B already inverted for SUB) agree in sign, sum does not.
    always_comb begin
        zero_d = hi ? ({sy, lo_q} == '0) : zero_q;
        ovf_d  = hi ? (arith && (sa[SLICE_W-1] == sb[SLICE_W-1]) && (sy[SLICE_W-1] != sa[SLICE_W-1])) : ovf_q;
    end
    always_ff @(posedge clk) begin
        zero_q <= rst ? 1'b0 : zero_d;
        ovf_q  <= rst ? 1'b0 : ovf_d;
    end
    assign rsp_zero = zero_q;
    assign rsp_ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus with a scoreboard queue checked by an independent response monitor.
module tb_alu_arbiter;
    typedef struct {
        logic        id;
        logic [15:0] res;
        logic        cout;
        logic        zero;
        logic        ovf;
    } exp_t;

    localparam logic [1:0] AND_OP = 2'b00;
    localparam logic [1:0] OR_OP  = 2'b01;
    localparam logic [1:0] ADD_OP = 2'b10;
    localparam logic [1:0] SUB_OP = 2'b11;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_cout, busy;
    logic [15:0] rsp_result;
`ifdef ALU_ARB_FLAGS_EN
    logic        rsp_zero, rsp_ovf;
`endif

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0, n_fail = 0, cyc = 0, acc_cyc = 0;
    logic prev_valid = 1'b0;

    alu_arbiter #(.SLICE_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_op   (req0_op),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_op   (req1_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_result(rsp_result),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
`ifdef ALU_ARB_FLAGS_EN
        ,
        .rsp_zero  (rsp_zero),
        .rsp_ovf   (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic id, input logic [15:0] res, input logic cout,
                                input logic zero, input logic ovf);
        exp_t e;
        e.id = id; e.res = res; e.cout = cout; e.zero = zero; e.ovf = ovf;
        return e;
    endfunction

    // Response monitor: latency from the accept cycle, then pop-and-compare on each consumed result.
    always @(negedge clk) begin
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_cyc = cyc;
        if (rsp_valid && !prev_valid) chk("rsp_latency", cyc - acc_cyc, 3);
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id %0d result %0h expected no response", rsp_id, rsp_result);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_id", rsp_id, mon_e.id);
                chk("rsp_result", rsp_result, mon_e.res);
                chk("rsp_cout", rsp_cout, mon_e.cout);
`ifdef ALU_ARB_FLAGS_EN
                chk("rsp_zero", rsp_zero, mon_e.zero);
                chk("rsp_ovf", rsp_ovf, mon_e.ovf);
`endif
            end
        end
        prev_valid = rsp_valid;
    end

    task automatic drive(input bit id, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    // Waits for the accept, then scrambles the inputs so a late change would corrupt the result.
    task automatic wait_ready(input bit id);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(id ? req1_ready : req0_ready) && n < 30);
        chk(id ? "req1_accept" : "req0_accept", id ? req1_ready : req0_ready, 1);
        @(posedge clk);
        #1;
        drive(id, 1'b0, 16'hDEAD, 16'hBEEF, SUB_OP);
    endtask

    task automatic issue(input bit id, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                         input bit push, input exp_t e);
        if (push) sb.push_back(e);
        drive(id, 1'b1, a, b, op);
        wait_ready(id);
    endtask

    task automatic tie();
        sb.push_back(mk(1'b0, 16'hF000, 1'b0, 1'b0, 1'b0));
        sb.push_back(mk(1'b1, 16'h0FF0, 1'b0, 1'b0, 1'b0));
        drive(1'b0, 1'b1, 16'hF0F0, 16'hFF00, AND_OP);
        drive(1'b1, 1'b1, 16'h0F00, 16'h00F0, OR_OP);
        wait_ready(1'b0);
        wait_ready(1'b1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rsp_result"}, rsp_result, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_rsp_cout"}, rsp_cout, 0);
`ifdef ALU_ARB_FLAGS_EN
        chk({tag, "_rsp_zero"}, rsp_zero, 0);
        chk({tag, "_rsp_ovf"}, rsp_ovf, 0);
`endif
    endtask

    initial begin
        int n;
        req0_valid = 1'b1;
        @(negedge clk);
        chk("ready0_in_reset", req0_ready, 0);
        @(negedge clk);
        chk("ready0_in_reset2", req0_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req0_valid = 1'b0;
        @(negedge clk);
        chk_zero_outputs("reset");
        @(posedge clk);
        #1;

        tie();
        tie();

        issue(1'b0, 16'h00FF, 16'h0001, ADD_OP, 1'b1, mk(1'b0, 16'h0100, 1'b0, 1'b0, 1'b0));
        issue(1'b1, 16'h0000, 16'h0001, SUB_OP, 1'b1, mk(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0));
        issue(1'b1, 16'h1234, 16'h1234, SUB_OP, 1'b1, mk(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0));
        issue(1'b0, 16'h7FFF, 16'h0001, ADD_OP, 1'b1, mk(1'b0, 16'h8000, 1'b0, 1'b0, 1'b1));
        issue(1'b1, 16'hFFFF, 16'h0001, ADD_OP, 1'b1, mk(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0));
        issue(1'b0, 16'h8000, 16'h0001, SUB_OP, 1'b1, mk(1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b1));
        issue(1'b1, 16'hA5A5, 16'h0F0F, OR_OP,  1'b1, mk(1'b1, 16'hAFAF, 1'b0, 1'b0, 1'b0));
        issue(1'b0, 16'h0F0F, 16'hF0F0, AND_OP, 1'b1, mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0));
        wait_drain();

        rsp_ready = 1'b0;
        issue(1'b0, 16'h1111, 16'h2222, ADD_OP, 1'b1, mk(1'b0, 16'h3333, 1'b0, 1'b0, 1'b0));
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_valid", rsp_valid, 1);
        sb.push_back(mk(1'b1, 16'h0002, 1'b1, 1'b0, 1'b0));
        drive(1'b1, 1'b1, 16'h0005, 16'h0003, SUB_OP);
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_rsp_result", rsp_result, 16'h3333);
            chk("stall_rsp_id", rsp_id, 0);
            chk("stall_rsp_cout", rsp_cout, 0);
            chk("stall_busy", busy, 1);
            chk("stall_req1_ready", req1_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_busy", busy, 0);
        chk("release_req1_ready", req1_ready, 1);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 16'h0000, 16'h0000, AND_OP);
        wait_drain();

        issue(1'b0, 16'h0101, 16'h0101, ADD_OP, 1'b0, mk(1'b0, 16'h0202, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 1'b1, 16'h0001, 16'h0001, ADD_OP);
        @(negedge clk);
        chk("ready1_in_reset", req1_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b0, 16'h0000, 16'h0000, AND_OP);
        @(negedge clk);
        chk_zero_outputs("midop_reset");
        @(posedge clk);
        #1;
        issue(1'b1, 16'h0003, 16'h0004, ADD_OP, 1'b1, mk(1'b1, 16'h0007, 1'b0, 1'b0, 1'b0));
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: SLICE_W, default 8, ALU slice width; operand/result width is 2*SLICE_W (16 by default).
REQ-002 SHALL have ports, in this order:
- clk, input, 1, the single clock.
- rst, input, 1, synchronous, active-high reset.
- reqN_valid, input, 1, N=0,1: request present.
- reqN_ready, output, 1: request accepted this cycle.
- reqN_a, input, 2*SLICE_W: operand A.
- reqN_b, input, 2*SLICE_W: operand B.
- reqN_op, input, 2: shared ALU_Operation enum (AND=00, OR=01, ADD=10, SUB=11).
- rsp_valid, output, 1: result present.
- rsp_ready, input, 1: consumer accepts result.
- rsp_id, output, 1: requester index of the result.
- rsp_result, output, 2*SLICE_W: operation result.
- rsp_cout, output, 1: final carry out; 0 for AND/OR.
- busy, output, 1: state is not IDLE.

Function
REQ-003 SHALL share one SLICE_W-bit ALU slice between two requesters; each request SHALL execute as two passes, low half then high half.
REQ-004 SHALL use FSM states IDLE, LO, HI and DONE.
- IDLE->LO on grant.
- LO->HI unconditionally.
- HI->DONE unconditionally.
- DONE->IDLE when rsp_ready=1.
REQ-005 reqN_ready SHALL be high only in IDLE and only for the granted requester; a handshake is valid&&ready in the same cycle.
REQ-006 On a handshake, SHALL register a, b, op and id; later changes to request inputs SHALL NOT affect the operation in flight.
REQ-007 Arbitration SHALL be round-robin.
- Single valid requester: that requester wins.
- Both valid: the requester not served last wins.
- The last-served pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-008 Slice carry-in SHALL be:
- LO pass: 1 for SUB (A + ~B + 1), else 0.
- HI pass: the carry out registered from the LO pass.
REQ-009 SUB SHALL present ~B to the slice; rsp_cout=1 means no borrow.
REQ-010 rsp_valid SHALL rise exactly 3 cycles after the handshake edge and hold until rsp_ready.
REQ-011 rsp_result, rsp_id and rsp_cout SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-012 No request SHALL be accepted in LO, HI or DONE; the earliest next accept is the cycle after the DONE->IDLE transition.
REQ-013 Width rule: results wrap modulo 2^(2*SLICE_W); the overflow bit goes to rsp_cout only.

Reset
REQ-014 When rst=1 at a clock edge, the FSM SHALL go to IDLE, the RR pointer to 1, and rsp_valid, rsp_result, rsp_id, rsp_cout and busy SHALL all be 0.
REQ-015 A reset mid-operation SHALL discard the in-flight request without producing a response; reqN_ready SHALL be 0 during the reset cycle.

Configuration
REQ-016 With ALU_ARB_FLAGS_EN defined, the block SHALL add two outputs:
- rsp_zero: result==0.
- rsp_ovf: signed overflow for ADD/SUB, 0 for AND/OR.
Both SHALL follow the timing and stability rules of rsp_result and reset to 0.
REQ-017 Without ALU_ARB_FLAGS_EN, these ports and their logic SHALL be absent.

Structure
REQ-018 The ALU_Operation enum, the FSM state enum and a request struct (a, b, op) SHALL live in shared package alu_pkg.
REQ-019 Arbitration SHALL be a sub-module rr_arbiter2 (inputs valid[1:0], advance; outputs grant[1:0]). The slice datapath SHALL be the existing 8-bit ALU instantiated once.

Verification
REQ-020 req0 ADD 0x00FF+0x0001 -> rsp_result=0x0100, rsp_cout=0, rsp_id=0, rsp_valid 3 cycles after the accept.
REQ-021 req1 SUB 0x0000-0x0001 -> 0xFFFF, cout=0; SUB 0x1234-0x1234 -> 0x0000, cout=1 (flags build: zero=1); ADD 0x7FFF+0x0001 flags build -> ovf=1.
REQ-022 Both valid right after reset with AND 0xF0F0&0xFF00 and OR 0x0F00|0x00F0, rsp_ready=1 -> id0 result 0xF000 first, then id1 result 0x0FF0; repeat the tie -> id0 wins again.
REQ-023 rsp_ready held 0 for 5 cycles in DONE -> outputs stable, reqN_ready=0, busy=1; release -> IDLE next cycle.
REQ-024 rst pulsed during HI -> no rsp_valid, busy=0 and outputs zero the next cycle, and a new request is accepted normally.
